// File: rtl/idu_axi_initiator_if.sv
`default_nettype none
// ============================================================================
//  Module      : idu_axi_initiator_if
//  Description : AXI4 bus bundle (AW/W/B/AR/R) shared by the IDU initiator
//                and target. The master modport drives requests and write
//                data; the slave modport answers them.
//  Revision    : 1.0  initial release
// ============================================================================
interface idu_axi_initiator_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_SIZE_WIDTH = 3
);
    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;

    // Write address channel
    logic [AXI_ADDR_WIDTH-1:0] AWADDR;
    logic [AXI_LEN_WIDTH-1:0]  AWLEN;
    logic [AXI_SIZE_WIDTH-1:0] AWSIZE;
    logic [1:0]                AWBURST;
    logic                      AWVALID;
    logic                      AWREADY;
    // Write data channel
    logic [AXI_DATA_WIDTH-1:0] WDATA;
    logic [STRB_WIDTH-1:0]     WSTRB;
    logic                      WLAST;
    logic                      WVALID;
    logic                      WREADY;
    // Write response channel
    logic [1:0]                BRESP;
    logic                      BVALID;
    logic                      BREADY;
    // Read address channel
    logic [AXI_ADDR_WIDTH-1:0] ARADDR;
    logic [AXI_LEN_WIDTH-1:0]  ARLEN;
    logic [AXI_SIZE_WIDTH-1:0] ARSIZE;
    logic [1:0]                ARBURST;
    logic                      ARVALID;
    logic                      ARREADY;
    // Read data channel
    logic [AXI_DATA_WIDTH-1:0] RDATA;
    logic [1:0]                RRESP;
    logic                      RLAST;
    logic                      RVALID;
    logic                      RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY,
        output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface
`default_nettype wire

// File: rtl/idu_axi_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : idu_axi_initiator
//  Description : Single-outstanding AXI4 master for the IDU. Converts one
//                command into an INCR burst on AW/W/B or AR/R and streams
//                beat data to/from the internal side. Misaligned or 4 KB
//                crossing commands are rejected without bus activity.
//  Revision    : 1.0  initial release
// ============================================================================
module idu_axi_initiator #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_LEN_WIDTH  = 8,
    parameter int AXI_SIZE_WIDTH = 3
) (
    input  wire logic                      ACLK,
    input  wire logic                      ARESETn,
    // command side
    input  wire logic                      cmd_valid,
    output logic                           cmd_ready,
    input  wire logic                      cmd_write,
    input  wire logic [AXI_ADDR_WIDTH-1:0] cmd_addr,
    input  wire logic [AXI_LEN_WIDTH-1:0]  cmd_len,
    // write-data stream
    input  wire logic [AXI_DATA_WIDTH-1:0] wr_data,
    input  wire logic                      wr_valid,
    output logic                           wr_ready,
    // read-data stream
    output logic [AXI_DATA_WIDTH-1:0]      rd_data,
    output logic                           rd_valid,
    output logic                           rd_last,
    // completion
    output logic                           done,
    output logic                           err,
    // AXI bus
    idu_axi_initiator_if.master            m_axi
);

    localparam int STRB_WIDTH = AXI_DATA_WIDTH / 8;
    // Wide enough for addr[11:0] + 4*(len+1) without overflow.
    localparam int SPAN_W = (((AXI_LEN_WIDTH + 2) > 12) ? (AXI_LEN_WIDTH + 2) : 12) + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WADDR  = 3'd1,
        S_WDATA  = 3'd2,
        S_WRESP  = 3'd3,
        S_RADDR  = 3'd4,
        S_RDATA  = 3'd5,
        S_REJECT = 3'd6
    } state_t;

    state_t                    state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [AXI_LEN_WIDTH-1:0]  len_q,   len_d;
    logic [AXI_LEN_WIDTH-1:0]  cnt_q,   cnt_d;
    logic                      rerr_q,  rerr_d;
    logic                      done_q,  done_d;
    logic                      err_q,   err_d;

    logic                      last_beat;
    logic                      misaligned;
    logic                      crosses_4k;
    logic [SPAN_W-1:0]         span_end;
    logic                      rbeat_err;

    assign last_beat  = (cnt_q == len_q);
    assign misaligned = (cmd_addr[1:0] != 2'b00);
    assign span_end   = SPAN_W'(cmd_addr[11:0]) + (SPAN_W'(cmd_len) << 2) + SPAN_W'(4);
    assign crosses_4k = (span_end > SPAN_W'(4096));
    // Error contribution of the current read beat, folded into the sticky flag.
    assign rbeat_err  = rerr_q | (m_axi.RRESP != 2'b00) | (m_axi.RLAST != last_beat);

    // State and datapath registers; async reset drops every valid at once.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rerr_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rerr_q  <= rerr_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state, beat counting and completion status.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rerr_d  = rerr_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_len;
                    cnt_d   = '0;
                    rerr_d  = 1'b0;
                    if (misaligned || crosses_4k) state_d = S_REJECT;
                    else if (cmd_write)           state_d = S_WADDR;
                    else                          state_d = S_RADDR;
                end
            end
            S_WADDR: if (m_axi.AWREADY) state_d = S_WDATA;
            S_RADDR: if (m_axi.ARREADY) state_d = S_RDATA;
            S_WDATA: begin
                if (wr_valid && m_axi.WREADY) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (m_axi.BVALID) begin
                    done_d  = 1'b1;
                    err_d   = (m_axi.BRESP != 2'b00);
                    state_d = S_IDLE;
                end
            end
            S_RDATA: begin
                if (m_axi.RVALID) begin
                    cnt_d  = cnt_q + 1'b1;
                    rerr_d = rbeat_err;
                    // The burst ends on our own count, whatever RLAST says.
                    if (last_beat) begin
                        done_d  = 1'b1;
                        err_d   = rbeat_err;
                        state_d = S_IDLE;
                    end
                end
            end
            S_REJECT: begin
                done_d  = 1'b1;
                err_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Command and internal stream outputs.
    assign cmd_ready = (state_q == S_IDLE);
    assign wr_ready  = (state_q == S_WDATA) && m_axi.WREADY;
    assign rd_data   = m_axi.RDATA;
    assign rd_valid  = (state_q == S_RDATA) && m_axi.RVALID;
    assign rd_last   = (state_q == S_RDATA) && last_beat;
    assign done      = done_q;
    assign err       = err_q;

    // AXI request channels; address and length come straight from the latches.
    assign m_axi.AWADDR  = addr_q;
    assign m_axi.AWLEN   = len_q;
    assign m_axi.AWSIZE  = AXI_SIZE_WIDTH'(2);
    assign m_axi.AWBURST = 2'b01;
    assign m_axi.AWVALID = (state_q == S_WADDR);
    assign m_axi.WDATA   = wr_data;
    assign m_axi.WSTRB   = {STRB_WIDTH{1'b1}};
    assign m_axi.WLAST   = (state_q == S_WDATA) && last_beat;
    assign m_axi.WVALID  = (state_q == S_WDATA) && wr_valid;
    assign m_axi.BREADY  = (state_q == S_WRESP);
    assign m_axi.ARADDR  = addr_q;
    assign m_axi.ARLEN   = len_q;
    assign m_axi.ARSIZE  = AXI_SIZE_WIDTH'(2);
    assign m_axi.ARBURST = 2'b01;
    assign m_axi.ARVALID = (state_q == S_RADDR);
    assign m_axi.RREADY  = (state_q == S_RDATA);

endmodule
`default_nettype wire

// File: tb/tb_idu_axi_initiator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_idu_axi_initiator
//  Description : Directed self-checking bench for idu_axi_initiator. The
//                bench plays the AXI target side directly on the interface.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_idu_axi_initiator;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [31:0] wr_data = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_last;
    logic        done;
    logic        err;

    int checks = 0;
    int passes = 0;

    idu_axi_initiator_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
                           .AXI_LEN_WIDTH(8), .AXI_SIZE_WIDTH(3)) bus ();

    idu_axi_initiator #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32),
                        .AXI_LEN_WIDTH(8), .AXI_SIZE_WIDTH(3)) dut (
        .ACLK      (ACLK),
        .ARESETn   (ARESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_last   (rd_last),
        .done      (done),
        .err       (err),
        .m_axi     (bus)
    );

    always #5 ACLK = ~ACLK;

    task automatic slave_idle();
        bus.AWREADY = 1'b0; bus.WREADY = 1'b0;
        bus.BVALID  = 1'b0; bus.BRESP  = 2'b00;
        bus.ARREADY = 1'b0; bus.RVALID = 1'b0;
        bus.RDATA   = '0;   bus.RRESP  = 2'b00; bus.RLAST = 1'b0;
    endtask

    task automatic test_reset();
        ARESETn = 1'b0;
        repeat (2) @(negedge ACLK);
        #1;
        checks++;
        if ({cmd_ready, bus.AWVALID, bus.ARVALID, bus.WVALID, bus.WLAST, bus.BREADY, bus.RREADY,
             wr_ready, rd_valid, rd_last, done, err} !== 12'b1000_0000_0000)
            $display("FAIL reset_ctrl: got %b required %b",
                     {cmd_ready, bus.AWVALID, bus.ARVALID, bus.WVALID, bus.WLAST, bus.BREADY, bus.RREADY,
                      wr_ready, rd_valid, rd_last, done, err}, 12'b1000_0000_0000);
        else passes++;
        checks++;
        if ({bus.AWADDR, bus.ARADDR, bus.AWLEN, bus.ARLEN} !== 80'h0)
            $display("FAIL reset_addr: got %h required 0",
                     {bus.AWADDR, bus.ARADDR, bus.AWLEN, bus.ARLEN});
        else passes++;
        @(negedge ACLK);
        ARESETn = 1'b1;
    endtask

    task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
        @(negedge ACLK);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        #1;
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL cmd_ready_idle: got %b required 1", cmd_ready);
        else passes++;
        @(negedge ACLK);
        cmd_valid = 1'b0;
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len,
                            input logic [1:0] bresp, input bit gappy);
        logic [31:0] exp_d;
        int idx;
        int cyc;
        send_cmd(1'b1, addr, len);
        checks++;
        if ({bus.AWVALID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST, cmd_ready} !==
            {1'b1, addr, len, 3'd2, 2'd1, 1'b0})
            $display("FAIL aw_req: got v=%b a=%h l=%0d s=%0d b=%0d rdy=%b required v=1 a=%h l=%0d s=2 b=1 rdy=0",
                     bus.AWVALID, bus.AWADDR, bus.AWLEN, bus.AWSIZE, bus.AWBURST, cmd_ready, addr, len);
        else passes++;
        // AWREADY arrives one cycle late; the request must hold.
        @(negedge ACLK);
        bus.AWREADY = 1'b1;
        #1;
        checks++;
        if ({bus.AWVALID, bus.AWADDR} !== {1'b1, addr})
            $display("FAIL aw_hold: got v=%b a=%h required v=1 a=%h", bus.AWVALID, bus.AWADDR, addr);
        else passes++;
        @(negedge ACLK);
        bus.AWREADY = 1'b0;
        #1;
        checks++;
        if (bus.AWVALID !== 1'b0) $display("FAIL aw_drop: got %b required 0", bus.AWVALID);
        else passes++;
        idx = 0;
        cyc = 0;
        while (idx <= int'(len) && cyc < 400) begin
            exp_d       = 32'hC0DE_0000 + idx * 32'h0101;
            wr_data     = exp_d;
            wr_valid    = gappy ? ((cyc % 3) != 2) : 1'b1;
            bus.WREADY  = gappy ? ((cyc % 4) != 1) : 1'b1;
            #1;
            if (wr_valid && bus.WREADY) begin
                checks++;
                if ({bus.WVALID, bus.WDATA, bus.WSTRB, bus.WLAST, wr_ready} !==
                    {1'b1, exp_d, 4'hF, (idx == int'(len)), 1'b1})
                    $display("FAIL w_beat%0d: got v=%b d=%h s=%h l=%b r=%b required v=1 d=%h s=f l=%b r=1",
                             idx, bus.WVALID, bus.WDATA, bus.WSTRB, bus.WLAST, wr_ready,
                             exp_d, (idx == int'(len)));
                else passes++;
                idx++;
            end
            cyc++;
            @(negedge ACLK);
        end
        wr_valid   = 1'b0;
        bus.WREADY = 1'b0;
        checks++;
        if (idx != int'(len) + 1) $display("FAIL w_timeout: got %0d beats required %0d", idx, int'(len) + 1);
        else passes++;
        #1;
        checks++;
        if ({bus.BREADY, bus.WVALID, bus.AWVALID} !== 3'b100)
            $display("FAIL b_ready: got %b required 100", {bus.BREADY, bus.WVALID, bus.AWVALID});
        else passes++;
        bus.BVALID = 1'b1;
        bus.BRESP  = bresp;
        @(negedge ACLK);
        bus.BVALID = 1'b0;
        bus.BRESP  = 2'b00;
        #1;
        checks++;
        if ({done, err} !== {1'b1, (bresp != 2'b00)})
            $display("FAIL w_done: got done=%b err=%b required done=1 err=%b", done, err, (bresp != 2'b00));
        else passes++;
        @(negedge ACLK);
        #1;
        checks++;
        if ({done, err, cmd_ready} !== 3'b001)
            $display("FAIL w_done_pulse: got %b required 001", {done, err, cmd_ready});
        else passes++;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                           input int rlast_at, input int rresp_at, input logic exp_err);
        logic [31:0] exp_d;
        send_cmd(1'b0, addr, len);
        checks++;
        if ({bus.ARVALID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.AWVALID} !==
            {1'b1, addr, len, 3'd2, 2'd1, 1'b0})
            $display("FAIL ar_req: got v=%b a=%h l=%0d s=%0d b=%0d awv=%b required v=1 a=%h l=%0d s=2 b=1 awv=0",
                     bus.ARVALID, bus.ARADDR, bus.ARLEN, bus.ARSIZE, bus.ARBURST, bus.AWVALID, addr, len);
        else passes++;
        bus.ARREADY = 1'b1;
        @(negedge ACLK);
        bus.ARREADY = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            exp_d      = 32'hDEADBEEF ^ (i * 32'h0101_0101);
            bus.RVALID = 1'b1;
            bus.RDATA  = exp_d;
            bus.RLAST  = (i == rlast_at);
            bus.RRESP  = (i == rresp_at) ? 2'b10 : 2'b00;
            #1;
            checks++;
            if ({rd_valid, rd_data, rd_last, bus.RREADY, bus.ARVALID} !==
                {1'b1, exp_d, (i == int'(len)), 1'b1, 1'b0})
                $display("FAIL r_beat%0d: got v=%b d=%h l=%b rr=%b arv=%b required v=1 d=%h l=%b rr=1 arv=0",
                         i, rd_valid, rd_data, rd_last, bus.RREADY, bus.ARVALID, exp_d, (i == int'(len)));
            else passes++;
            @(negedge ACLK);
        end
        slave_idle();
        #1;
        checks++;
        if ({done, err, rd_valid} !== {1'b1, exp_err, 1'b0})
            $display("FAIL r_done: got done=%b err=%b rv=%b required done=1 err=%b rv=0",
                     done, err, rd_valid, exp_err);
        else passes++;
        @(negedge ACLK);
        #1;
        checks++;
        if ({done, err, cmd_ready} !== 3'b001)
            $display("FAIL r_done_pulse: got %b required 001", {done, err, cmd_ready});
        else passes++;
    endtask

    task automatic test_write_basic();
        do_write(32'h0000_0100, 8'd3, 2'b00, 1'b0);
    endtask

    task automatic test_read_single();
        do_read(32'h0000_0040, 8'd0, 0, -1, 1'b0);
    endtask

    task automatic test_write_gaps();
        do_write(32'h0000_0800, 8'd7, 2'b00, 1'b1);
    endtask

    task automatic test_errors();
        do_write(32'h0000_0200, 8'd1, 2'b10, 1'b0);
        do_read(32'h0000_0300, 8'd3, 1, -1, 1'b1);   // RLAST on beat 2 of 4
        do_read(32'h0000_0400, 8'd2, 2, 1, 1'b1);    // RRESP error mid-burst
        do_read(32'h0000_0500, 8'd1, 1, -1, 1'b0);   // sticky flag cleared again
    endtask

    task automatic reject_case(input logic [31:0] addr, input logic [7:0] len);
        int k;
        send_cmd(1'b1, addr, len);
        checks++;
        if ({bus.AWVALID, bus.ARVALID, bus.WVALID} !== 3'b000)
            $display("FAIL rej_nobus_%h: got %b required 000", addr, {bus.AWVALID, bus.ARVALID, bus.WVALID});
        else passes++;
        k = 0;
        while (done !== 1'b1 && k < 2) begin
            @(negedge ACLK);
            #1;
            k++;
        end
        checks++;
        if ({done, err, bus.AWVALID} !== 3'b110)
            $display("FAIL rej_done_%h: got %b required 110", addr, {done, err, bus.AWVALID});
        else passes++;
        @(negedge ACLK);
        #1;
        checks++;
        if ({done, err, cmd_ready} !== 3'b001)
            $display("FAIL rej_pulse_%h: got %b required 001", addr, {done, err, cmd_ready});
        else passes++;
    endtask

    task automatic test_reject();
        reject_case(32'h0000_0FF8, 8'd3);   // ends at 0x1008
        reject_case(32'h0000_0102, 8'd0);   // misaligned
        do_write(32'h0000_0FF0, 8'd3, 2'b00, 1'b0);  // ends exactly at 0x1000: legal
    endtask

    task automatic test_long_read();
        do_read(32'h0000_0000, 8'd255, 255, -1, 1'b0);
    endtask

    task automatic test_reset_midburst();
        send_cmd(1'b1, 32'h0000_0600, 8'd3);
        bus.AWREADY = 1'b1;
        @(negedge ACLK);
        bus.AWREADY = 1'b0;
        wr_valid    = 1'b1;
        bus.WREADY  = 1'b1;
        wr_data     = 32'h1111_2222;
        repeat (2) @(negedge ACLK);
        #1;
        checks++;
        if (bus.WVALID !== 1'b1) $display("FAIL pre_reset_wvalid: got %b required 1", bus.WVALID);
        else passes++;
        ARESETn = 1'b0;
        #1;
        checks++;
        if ({bus.AWVALID, bus.WVALID, bus.BREADY, wr_ready, done, err} !== 6'b0)
            $display("FAIL midreset_drop: got %b required 000000",
                     {bus.AWVALID, bus.WVALID, bus.BREADY, wr_ready, done, err});
        else passes++;
        wr_valid = 1'b0;
        slave_idle();
        @(negedge ACLK);
        ARESETn = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, done, bus.AWADDR, bus.AWLEN} !== {2'b10, 32'h0, 8'h0})
            $display("FAIL post_reset: got rdy=%b done=%b a=%h l=%0d required rdy=1 done=0 a=0 l=0",
                     cmd_ready, done, bus.AWADDR, bus.AWLEN);
        else passes++;
        do_read(32'h0000_0700, 8'd1, 1, -1, 1'b0);
    endtask

    initial begin
        slave_idle();
        #3;
        test_reset();
        test_write_basic();
        test_read_single();
        test_write_gaps();
        test_errors();
        test_reject();
        test_long_read();
        test_reset_midburst();
        repeat (2) @(negedge ACLK);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/idu_axi_initiator.md
Name: idu_axi_initiator

Overview:
AXI master (initiator) for the IDU. It turns single-command requests from internal logic into INCR AXI bursts on either the AW/W/B or the AR/R channels, and streams data between the internal side and AXI. It drives the same bus the IDU's AXI target responds on, so a bench can connect the two back-to-back. Only one transaction is outstanding at a time.

Parameters:
AXI_ADDR_WIDTH, 32, byte address width
AXI_DATA_WIDTH, 32, data width; the block supports 32 only (4 byte lanes)
AXI_LEN_WIDTH, 8, burst length field width (beats = LEN+1)
AXI_SIZE_WIDTH, 3, size field width

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
cmd_valid / cmd_ready  in / out  1  command handshake
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  AXI_ADDR_WIDTH  burst start byte address
cmd_len  in  AXI_LEN_WIDTH  beats minus one
wr_data  in  AXI_DATA_WIDTH  write beat data
wr_valid / wr_ready  in / out  1  write-data stream handshake
rd_data  out  AXI_DATA_WIDTH  read beat data (= RDATA)
rd_valid / rd_last  out  1  read beat strobe / final beat
done  out  1  one-cycle completion pulse
err  out  1  completion status, valid while done=1
AWADDR / ARADDR  out  AXI_ADDR_WIDTH  burst address
AWLEN / ARLEN  out  AXI_LEN_WIDTH  burst length
AWSIZE / ARSIZE  out  AXI_SIZE_WIDTH  constant 3'b010
AWBURST / ARBURST  out  2  constant 2'b01 (INCR)
AWVALID / ARVALID  out  1  address valid
AWREADY / ARREADY  in  1  address ready
WDATA / WSTRB / WLAST / WVALID  out  32 / 4 / 1 / 1  write data channel; WSTRB constant 4'hF
WREADY  in  1  write ready
BRESP / BVALID  in  2 / 1  write response
BREADY  out  1  write response ready
RDATA / RRESP / RLAST / RVALID  in  32 / 2 / 1 / 1  read data channel
RREADY  out  1  read ready

Behaviour:
- Reset (async, any state): state IDLE. AWVALID, ARVALID, WVALID, WLAST, BREADY, RREADY, wr_ready, rd_valid, rd_last, done and err are all 0. AWADDR, ARADDR, AWLEN, ARLEN and the beat counter are 0. cmd_ready = 1. A reset mid-burst drops all valids immediately; no completion is reported.
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA, REJECT.
- IDLE: cmd_ready = 1 (combinational, IDLE only). On cmd_valid && cmd_ready the block latches addr and len and clears the beat counter.
- Reject check: the command goes to REJECT if cmd_addr[1:0] != 0, or if cmd_addr[11:0] + 4*(len+1) > 4096 (4 KB crossing). No AXI activity is generated. REJECT: done = 1, err = 1 for one cycle, then IDLE.
- Otherwise the block goes to WADDR or RADDR. AxVALID rises the cycle after acceptance and stays high, with AxADDR/AxLEN stable, until the AxREADY handshake. AxREADY asserted before AxVALID is legal.
- WDATA: WDATA = wr_data, WVALID = wr_valid, wr_ready = WREADY (combinational, this state only). A beat is counted only on WVALID && WREADY. WLAST = (count == len). The last-beat handshake moves the block to WRESP.
- WRESP: BREADY = 1. On BVALID: done = 1, err = (BRESP != 0), then IDLE.
- RDATA: RREADY = 1. rd_valid = RVALID, rd_data = RDATA, rd_last = (count == len). A beat is counted on RVALID.
- Read error flag (sticky per transaction) is set by:
  - RRESP != 0 on any beat;
  - RLAST mismatching (count == len) on any beat.
- The burst ends on the beat where count == len, regardless of RLAST. On that beat: done = 1 the following cycle, err = sticky flag, then IDLE.
- Beat counter width is AXI_LEN_WIDTH. len = 255 gives 256 beats with no wrap error.
- done and err are registered. err is 0 whenever done = 0.
- cmd_valid while busy is ignored (cmd_ready = 0).

Test Plan:
1. Write addr 0x100, len 3, AWREADY one cycle late, WREADY = 1, BRESP 0 -> AWADDR 0x100, AWLEN 3, AWSIZE 2, AWBURST 1; 4 W beats with WLAST on beat 4; done = 1, err = 0.
2. Read addr 0x40, len 0, single R beat 0xDEADBEEF with RLAST = 1 -> ARLEN 0; rd_data 0xDEADBEEF, rd_valid = 1, rd_last = 1; then done = 1, err = 0.
3. Write len 7 with random wr_valid gaps and WREADY toggling -> exactly 8 handshakes, data in order, WLAST only on the 8th handshake.
4. BRESP = 2'b10 -> err = 1. Read len 3 with RLAST on beat 2 -> all 4 beats delivered, err = 1.
5. Write addr 0xFF8, len 3 -> no AWVALID; done = 1 and err = 1 within 2 cycles of acceptance. Write addr 0x102 -> same response.
6. Assert ARESETn low after 2 of 4 write beats -> AWVALID, WVALID and BREADY go 0 immediately; after release cmd_ready = 1 and a new read completes normally.
